// File: rtl/demux_pkg.sv
// Shared sizing and FSM encoding for the 1-to-32 serial-bit demux collector.
package demux_pkg;
  localparam int WIDTH = 32;
  localparam int SEL_W = $clog2(WIDTH);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;
endpackage

// File: rtl/decoder5to32.sv
// Lane-select decoder: one-hot lane strobe for an accepted bit; out-of-range selects decode to nothing.
module decoder5to32
  import demux_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en && (int'(sel) < WIDTH)) onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/demux1to32_collector.sv
// Routes serial bits into a 32-lane word and emits it on valid/ready when full or flushed.
// Optional build macro DEMUX_DUP_ERR_EN adds the dup_err duplicate-write pulse output.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both high at posedge clk;
// in_ready depends only on state (never on in_valid), and out_valid/out_word/out_mask stay
// stable until out_ready is seen high.
module demux1to32_collector
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [WIDTH-1:0] out_mask,
  output logic [SEL_W:0]   lane_count,
`ifdef DEMUX_DUP_ERR_EN
  output logic             dup_err,
`endif
  output state_t           fsm_state
);
  state_t           state, state_next;
  logic [WIDTH-1:0] data, data_next;
  logic [WIDTH-1:0] mask, mask_next;
  logic [SEL_W:0]   count, count_next;
  logic             accept;
  logic [WIDTH-1:0] lane_hit;
  logic             new_lane;
  logic             dup_hit;

  assign in_ready = (state == COLLECT);
  assign accept   = in_valid & in_ready;

  decoder5to32 u_dec (
    .en     (accept),
    .sel    (in_sel),
    .onehot (lane_hit)
  );

  assign new_lane = |(lane_hit & ~mask);
  assign dup_hit  = |(lane_hit & mask);

  always_comb begin
    state_next = state;
    data_next  = data;
    mask_next  = mask;
    count_next = count;
    case (state)
      COLLECT: begin
        // Accept is folded in first so flush and completion see the post-update mask.
        data_next  = (data & ~lane_hit) | (lane_hit & {WIDTH{in_bit}});
        mask_next  = mask | lane_hit;
        count_next = count + (SEL_W + 1)'(new_lane);
        if ((&mask_next) || (flush && (|mask_next))) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          data_next  = '0;
          mask_next  = '0;
          count_next = '0;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      data  <= '0;
      mask  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      data  <= data_next;
      mask  <= mask_next;
      count <= count_next;
    end
  end

`ifdef DEMUX_DUP_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) dup_err <= 1'b0;
    else       dup_err <= dup_hit;
  end
`else
  logic unused_dup;
  assign unused_dup = dup_hit;
`endif

  assign out_valid  = (state == HOLD);
  assign out_word   = data;
  assign out_mask   = mask;
  assign lane_count = count;
  assign fsm_state  = state;
endmodule

// File: tb/tb_demux1to32_collector.sv
// Directed self-checking bench for demux1to32_collector (default and DEMUX_DUP_ERR_EN builds).
module tb_demux1to32_collector;
  import demux_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic [4:0]  in_sel;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_mask;
  logic [5:0]  lane_count;
  logic        dup_err;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux1to32_collector dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .in_sel     (in_sel),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_mask   (out_mask),
    .lane_count (lane_count),
`ifdef DEMUX_DUP_ERR_EN
    .dup_err    (dup_err),
`endif
    .fsm_state  (fsm_state)
  );

`ifndef DEMUX_DUP_ERR_EN
  assign dup_err = 1'b0;
`endif

  // Inputs change 1 time unit after posedge; outputs are sampled there too.
  task automatic send(input logic [4:0] sel, input logic b, input logic fl);
    in_valid = 1'b1;
    in_sel   = sel;
    in_bit   = b;
    flush    = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_mask !== 32'h0 || out_word !== 32'h0) begin
      errors++; $display("FAIL reset_regs word=%h mask=%h exp=0/0", out_word, out_mask);
    end
    checks++;
    if (lane_count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", lane_count); end
    checks++;
    if (fsm_state !== COLLECT) begin errors++; $display("FAIL reset_state got=%0d exp=COLLECT", fsm_state); end
    checks++;
    if (dup_err !== 1'b0) begin errors++; $display("FAIL reset_dup_err got=%b exp=0", dup_err); end
  endtask

  task automatic test_fill_in_order();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid lane=%0d got=%b exp=0", i, out_valid); end
      send(5'(i), i[0], 1'b0);
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b exp=1", out_valid); end
    checks++;
    if (out_word !== 32'hAAAA_AAAA) begin errors++; $display("FAIL fill_word got=%h exp=aaaaaaaa", out_word); end
    checks++;
    if (out_mask !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fill_mask got=%h exp=ffffffff", out_mask); end
    checks++;
    if (lane_count !== 6'd32) begin errors++; $display("FAIL fill_count got=%0d exp=32", lane_count); end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fill_drain valid=%b ready=%b exp=0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 31; i >= 0; i--) send(5'(i), 1'b1, 1'b0);
    // An offer during HOLD must not be taken.
    in_valid = 1'b1;
    in_sel   = 5'd3;
    in_bit   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_handshake cyc=%0d valid=%b ready=%b exp=1/0", c, out_valid, in_ready);
      end
      checks++;
      if (out_word !== 32'hFFFF_FFFF || out_mask !== 32'hFFFF_FFFF || lane_count !== 6'd32) begin
        errors++; $display("FAIL hold_stable cyc=%0d word=%h mask=%h cnt=%0d exp=ffffffff/ffffffff/32",
                           c, out_word, out_mask, lane_count);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release valid=%b ready=%b exp=0/1", out_valid, in_ready);
    end
    checks++;
    if (out_word !== 32'h0 || out_mask !== 32'h0 || lane_count !== 6'd0) begin
      errors++; $display("FAIL hold_clear word=%h mask=%h cnt=%0d exp=0/0/0", out_word, out_mask, lane_count);
    end
  endtask

  task automatic test_flush_partial();
    for (int i = 0; i < 4; i++) send(5'(i), 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_pre_valid got=%b exp=0", out_valid); end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got=%b exp=1", out_valid); end
    checks++;
    if (out_word !== 32'h0000_000F || out_mask !== 32'h0000_000F) begin
      errors++; $display("FAIL flush_word word=%h mask=%h exp=0000000f/0000000f", out_word, out_mask);
    end
    checks++;
    if (lane_count !== 6'd4) begin errors++; $display("FAIL flush_count got=%0d exp=4", lane_count); end
    drain();
  endtask

  task automatic test_duplicate();
    send(5'd7, 1'b1, 1'b0);
    send(5'd7, 1'b0, 1'b0);
    checks++;
    if (lane_count !== 6'd1) begin errors++; $display("FAIL dup_count got=%0d exp=1", lane_count); end
    checks++;
    if (out_word !== 32'h0 || out_mask !== 32'h0000_0080) begin
      errors++; $display("FAIL dup_overwrite word=%h mask=%h exp=0/00000080", out_word, out_mask);
    end
`ifdef DEMUX_DUP_ERR_EN
    checks++;
    if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_err_pulse got=%b exp=1", dup_err); end
`endif
    for (int i = 0; i < 32; i++) begin
      if (i != 7) begin
        send(5'(i), 1'b1, 1'b0);
        checks++;
        if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_err_clear lane=%0d got=%b exp=0", i, dup_err); end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hFFFF_FF7F) begin
      errors++; $display("FAIL dup_word valid=%b word=%h exp=1/ffffff7f", out_valid, out_word);
    end
    checks++;
    if (lane_count !== 6'd32) begin errors++; $display("FAIL dup_final_count got=%0d exp=32", lane_count); end
    drain();
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 20; i++) send(5'(i), 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_mask !== 32'h0 || lane_count !== 6'd0) begin
      errors++; $display("FAIL abort_cleared valid=%b mask=%h cnt=%0d exp=0/0/0", out_valid, out_mask, lane_count);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_early_valid lane=%0d got=%b exp=0", i, out_valid); end
      send(5'(i), 1'b0, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h0 || out_mask !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL abort_word valid=%b word=%h mask=%h exp=1/0/ffffffff", out_valid, out_word, out_mask);
    end
    drain();
  endtask

  task automatic test_flush_edges();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL empty_flush valid=%b ready=%b exp=0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 31; i++) send(5'(i), 1'b1, 1'b0);
    send(5'd31, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 32'hFFFF_FFFF || out_word !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL flush_final valid=%b mask=%h word=%h exp=1/ffffffff/7fffffff", out_valid, out_mask, out_word);
    end
    checks++;
    if (lane_count !== 6'd32) begin errors++; $display("FAIL flush_final_count got=%0d exp=32", lane_count); end
    // Flush while holding has no effect; a single drain ends the emission.
    flush = 1'b1;
    drain();
    flush = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_mask !== 32'h0) begin
      errors++; $display("FAIL flush_single valid=%b mask=%h exp=0/0", out_valid, out_mask);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_sel    = 5'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_fill_in_order();
    test_backpressure();
    test_flush_partial();
    test_duplicate();
    test_reset_abort();
    test_flush_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
